// File: rtl/rmii_tx_ctrl_pkg.sv
// rmii_tx_ctrl_pkg: shared states, framing constants and the 2-bit CRC-32 step for the RMII transmitter.
// Optional PAD state exists only when RMII_TX_CTRL_PAD_EN is defined.
package rmii_tx_ctrl_pkg;
`ifdef RMII_TX_CTRL_PAD_EN
  typedef enum logic [2:0] {ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_IFG} state_e;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DATA, ST_FCS, ST_IFG} state_e;
`endif
  localparam int PREAMBLE_DIBITS = 28;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam int FCS_DIBITS = 16;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) c = (c >> 1) ^ ((c[0] ^ d[i]) ? CRC_POLY : 32'h0);
    return c;
  endfunction
endpackage

// File: rtl/rmii_tx_ctrl_fcs.sv
// eth_fcs_d2: reflected CRC-32 register advancing one dibit (LSB first) per enabled cycle.
// Ports: clk, rst (sync, active-high), clr_i (reload init), en_i (absorb dibit_i), dibit_i, crc_o (raw register).
module eth_fcs_d2
  import rmii_tx_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [1:0]  dibit_i,
  output logic [31:0] crc_o
);
  logic [31:0] crc_q, crc_d;
  always_comb crc_d = clr_i ? CRC_INIT : en_i ? crc_dibit(crc_q, dibit_i) : crc_q;
  always_ff @(posedge clk) crc_q <= rst ? CRC_INIT : crc_d;
  assign crc_o = crc_q;
endmodule

// File: rtl/rmii_tx_ctrl.sv
// rmii_tx_ctrl: RMII transmit framer (preamble, SFD, payload, optional zero pad, FCS, inter-frame gap).
// Ports: clk/rst (sync, active-high); s_data/s_valid/s_last/s_ready byte stream in;
// txd/tx_en RMII dibit out; busy (not IDLE); underrun (one-cycle abort pulse).
// Macro RMII_TX_CTRL_PAD_EN enables zero padding of short frames to MIN_FRAME_BYTES.
module rmii_tx_ctrl
  import rmii_tx_ctrl_pkg::*;
#(
  parameter int IFG_DIBITS      = 48,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [1:0] txd,
  output logic       tx_en,
  output logic       busy,
  output logic       underrun
);
  localparam int CW = $clog2((IFG_DIBITS > PREAMBLE_DIBITS ? IFG_DIBITS : PREAMBLE_DIBITS) + 1);
  if (IFG_DIBITS < 1) begin : g_bad_ifg
    $error("IFG_DIBITS must be at least 1");
  end
  if (MIN_FRAME_BYTES < 1) begin : g_bad_min
    $error("MIN_FRAME_BYTES must be at least 1");
  end
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic last_q, last_d;
  logic [1:0] txd_q, txd_d;
  logic tx_en_q, tx_en_d, s_ready_q, s_ready_d, busy_q, busy_d, underrun_q, underrun_d;
  logic crc_clr, crc_en;
  logic [31:0] crc;
`ifdef RMII_TX_CTRL_PAD_EN
  localparam int BW = $clog2(MIN_FRAME_BYTES + 1);
  logic [BW-1:0] bcnt_q, bcnt_d, bcnt_inc;
  assign bcnt_inc = (bcnt_q == BW'(MIN_FRAME_BYTES)) ? bcnt_q : bcnt_q + 1'b1;
`endif
  eth_fcs_d2 u_fcs (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .dibit_i(txd_d),
    .crc_o  (crc)
  );
  // Outputs are registered from the next-state values, so txd/tx_en/s_ready line up with state_q.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    byte_d = byte_q;
    last_d = last_q;
    underrun_d = 1'b0;
`ifdef RMII_TX_CTRL_PAD_EN
    bcnt_d = bcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
`ifdef RMII_TX_CTRL_PAD_EN
        bcnt_d = '0;
`endif
        if (s_valid) state_d = ST_PREAMBLE;
      end
      ST_PREAMBLE: if (cnt_q == CW'(PREAMBLE_DIBITS - 1)) begin
        state_d = ST_SFD;
        cnt_d = '0;
      end
      ST_DATA: if (cnt_q[1:0] == 2'd3 && last_q) begin
        cnt_d = '0;
`ifdef RMII_TX_CTRL_PAD_EN
        state_d = (bcnt_q < BW'(MIN_FRAME_BYTES)) ? ST_PAD : ST_FCS;
        bcnt_d = bcnt_inc;
`else
        state_d = ST_FCS;
`endif
      end
`ifdef RMII_TX_CTRL_PAD_EN
      ST_PAD: if (cnt_q[1:0] == 2'd3) begin
        cnt_d = '0;
        if (bcnt_q == BW'(MIN_FRAME_BYTES)) state_d = ST_FCS;
        else bcnt_d = bcnt_inc;
      end
`endif
      ST_FCS: if (cnt_q == CW'(FCS_DIBITS - 1)) begin
        state_d = ST_IFG;
        cnt_d = '0;
      end
      ST_IFG: if (cnt_q == CW'(IFG_DIBITS - 1)) begin
        state_d = ST_IDLE;
        cnt_d = '0;
      end
      default: ;
    endcase
    // s_ready_q marks the last dibit of SFD or of a non-final byte: take the next byte or abort.
    if (s_ready_q) begin
      cnt_d = '0;
      state_d = s_valid ? ST_DATA : ST_IFG;
      underrun_d = !s_valid;
      byte_d = s_valid ? s_data : byte_q;
      last_d = s_valid ? s_last : last_q;
`ifdef RMII_TX_CTRL_PAD_EN
      if (s_valid) bcnt_d = bcnt_inc;
`endif
    end
    tx_en_d = state_d != ST_IDLE && state_d != ST_IFG;
    busy_d = state_d != ST_IDLE;
    txd_d = state_d == ST_PREAMBLE ? 2'b01 :
            state_d == ST_SFD ? SFD_BYTE[{cnt_d[1:0], 1'b0} +: 2] :
            state_d == ST_DATA ? byte_d[{cnt_d[1:0], 1'b0} +: 2] :
            state_d == ST_FCS ? ~crc[{cnt_d[3:0], 1'b0} +: 2] : 2'b00;
    s_ready_d = cnt_d[1:0] == 2'd3 && (state_d == ST_SFD || (state_d == ST_DATA && !last_d));
    crc_clr = state_q == ST_IDLE && state_d == ST_PREAMBLE;
`ifdef RMII_TX_CTRL_PAD_EN
    crc_en = state_d == ST_DATA || state_d == ST_PAD;
`else
    crc_en = state_d == ST_DATA;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      byte_q <= '0;
      last_q <= 1'b0;
      txd_q <= '0;
      tx_en_q <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q <= 1'b0;
      underrun_q <= 1'b0;
`ifdef RMII_TX_CTRL_PAD_EN
      bcnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      byte_q <= byte_d;
      last_q <= last_d;
      txd_q <= txd_d;
      tx_en_q <= tx_en_d;
      s_ready_q <= s_ready_d;
      busy_q <= busy_d;
      underrun_q <= underrun_d;
`ifdef RMII_TX_CTRL_PAD_EN
      bcnt_q <= bcnt_d;
`endif
    end
  end
  assign txd = txd_q;
  assign tx_en = tx_en_q;
  assign s_ready = s_ready_q;
  assign busy = busy_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_rmii_tx_ctrl.sv
// tb_rmii_tx_ctrl: directed self-checking bench for rmii_tx_ctrl (default or RMII_TX_CTRL_PAD_EN build).
module tb_rmii_tx_ctrl;
  localparam int IFG = 48;
`ifdef RMII_TX_CTRL_PAD_EN
  localparam int PAD_MIN = 60;
`else
  localparam int PAD_MIN = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic s_ready, tx_en, busy, underrun;
  logic [1:0] txd;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] pay [0:127];
  logic [1:0] cap [0:1023];
  logic [7:0] expb [0:159];
  int ncap, nexp, n_ur, ur_at;

  always #10 clk = ~clk;

  rmii_tx_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .txd     (txd),
    .tx_en   (tx_en),
    .busy    (busy),
    .underrun(underrun)
  );

  function automatic int frame_dibits(input int n);
    return 4 * (12 + (n < PAD_MIN ? PAD_MIN : n));
  endfunction

  function automatic logic [7:0] cap_byte(input int i);
    return {cap[4*i+3], cap[4*i+2], cap[4*i+1], cap[4*i]};
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < nexp; i++) if (cap_byte(i) !== expb[i]) return i;
    return -1;
  endfunction

  // Expected wire bytes: preamble, SFD, payload (+ zero pad), FCS from a bytewise bit-serial CRC-32.
  task automatic build_exp(input int n);
    logic [31:0] c;
    logic [7:0] b;
    int m;
    m = n < PAD_MIN ? PAD_MIN : n;
    for (int i = 0; i < 7; i++) expb[i] = 8'h55;
    expb[7] = 8'hD5;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < m; i++) begin
      b = i < n ? pay[i] : 8'h00;
      expb[8+i] = b;
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB8_8320 : c >> 1;
    end
    c = ~c;
    for (int i = 0; i < 4; i++) expb[8+m+i] = c[8*i +: 8];
    nexp = 12 + m;
  endtask

  // Feeds pay[0..n-1] and captures txd while tx_en; returns on the first low tx_en cycle or at stop_at dibits.
  task automatic send_frame(input int n, input bit with_last, input int stop_at);
    int idx;
    bit started, ended;
    idx = 0; started = 0; ended = 0; ncap = 0; n_ur = 0; ur_at = -1;
    for (int cyc = 0; cyc < 4000 && !ended; cyc++) begin
      @(negedge clk);
      if (underrun) begin n_ur++; ur_at = ncap; end
      if (tx_en) begin
        started = 1;
        if (ncap < 1024) cap[ncap] = txd;
        ncap++;
      end
      s_valid = idx < n;
      s_data = pay[idx < 128 ? idx : 0];
      s_last = with_last && idx == n - 1;
      if (s_ready && idx < n) idx++;
      ended = (started && !tx_en) || (stop_at > 0 && ncap == stop_at);
    end
    if (!ended) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout got no frame end want frame end within 4000 cycles");
    end
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (busy && k < 200) begin
      k++;
      @(negedge clk);
      if (underrun) n_ur++;
    end
  endtask

  task automatic test_reset();
    rst = 1; s_valid = 1; s_data = 8'hA5;
    repeat (3) @(negedge clk);
    vectors++; if (tx_en !== 1'b0) begin miscompares++; $display("FAIL reset_tx_en got %b want 0", tx_en); end
    vectors++; if (txd !== 2'b00) begin miscompares++; $display("FAIL reset_txd got %b want 00", txd); end
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun got %b want 0", underrun); end
    rst = 0; s_valid = 0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_check_string();
    int d, k;
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    send_frame(9, 1, 0);
    build_exp(9);
    vectors++; if (ncap !== 4 * nexp) begin miscompares++; $display("FAIL str_len got %0d want %0d", ncap, 4 * nexp); end
    d = first_diff();
    vectors++; if (d != -1) begin miscompares++; $display("FAIL str_stream byte %0d got %h want %h", d, cap_byte(d), expb[d]); end
`ifndef RMII_TX_CTRL_PAD_EN
    vectors++;
    if ({cap_byte(20), cap_byte(19), cap_byte(18), cap_byte(17)} !== 32'hCBF4_3926) begin
      miscompares++;
      $display("FAIL str_fcs got %h want cbf43926", {cap_byte(20), cap_byte(19), cap_byte(18), cap_byte(17)});
    end
`endif
    wait_idle(k);
    vectors++; if (k != IFG) begin miscompares++; $display("FAIL str_ifg got %0d want %0d", k, IFG); end
    vectors++; if (n_ur != 0) begin miscompares++; $display("FAIL str_underrun got %0d want 0", n_ur); end
  endtask

  task automatic test_lengths();
    int lens [0:2];
    int d, k;
    lens[0] = 1; lens[1] = 14; lens[2] = 64;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < lens[t]; i++) pay[i] = t == 0 ? 8'h00 : 8'(i * 37 + 11);
      send_frame(lens[t], 1, 0);
      build_exp(lens[t]);
      vectors++; if (ncap !== frame_dibits(lens[t])) begin miscompares++; $display("FAIL len%0d_len got %0d want %0d", lens[t], ncap, frame_dibits(lens[t])); end
      d = first_diff();
      vectors++; if (d != -1) begin miscompares++; $display("FAIL len%0d_stream byte %0d got %h want %h", lens[t], d, cap_byte(d), expb[d]); end
`ifdef RMII_TX_CTRL_PAD_EN
      if (lens[t] == 14) begin
        vectors++; if (ncap != 288) begin miscompares++; $display("FAIL pad14_tx_en got %0d want 288", ncap); end
      end
`endif
      wait_idle(k);
    end
  endtask

  task automatic test_underrun();
    int k;
    pay[0] = 8'hC3; pay[1] = 8'h3C;
    send_frame(2, 0, 0);
    vectors++; if (n_ur != 1) begin miscompares++; $display("FAIL ur_count got %0d want 1", n_ur); end
    vectors++; if (ur_at != 40 || ncap != 40) begin miscompares++; $display("FAIL ur_tx_en got %0d/%0d want 40/40", ur_at, ncap); end
    wait_idle(k);
    vectors++; if (k != IFG) begin miscompares++; $display("FAIL ur_busy got %0d want %0d", k, IFG); end
    vectors++; if (n_ur != 1) begin miscompares++; $display("FAIL ur_single got %0d want 1", n_ur); end
  endtask

  task automatic test_back_to_back();
    int idx, len_a, len_b, low, idle, k;
    bit fallen, done;
    idx = 0; len_a = 0; len_b = 0; low = 0; idle = 0; fallen = 0; done = 0;
    for (int i = 0; i < 5; i++) pay[i] = 8'h90 + 8'(i);
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (tx_en) begin
        if (fallen) len_b++;
        else len_a++;
      end else if (len_b > 0) done = 1;
      else if (len_a > 0) begin
        fallen = 1;
        low++;
        if (!busy) idle++;
      end
      s_valid = idx < 5;
      s_data = pay[idx < 5 ? idx : 0];
      s_last = idx == 2 || idx == 4;
      if (s_ready && idx < 5) idx++;
    end
    if (!done) begin vectors++; miscompares++; $display("FAIL b2b_timeout got no second frame end want end within 3000 cycles"); end
    wait_idle(k);
    vectors++; if (len_a != frame_dibits(3)) begin miscompares++; $display("FAIL b2b_len_a got %0d want %0d", len_a, frame_dibits(3)); end
    vectors++; if (len_b != frame_dibits(2)) begin miscompares++; $display("FAIL b2b_len_b got %0d want %0d", len_b, frame_dibits(2)); end
    // The gap is the IFG state plus the single IDLE cycle that launches the next preamble.
    vectors++; if (low != IFG + 1) begin miscompares++; $display("FAIL b2b_gap got %0d want %0d", low, IFG + 1); end
    vectors++; if (idle != 1) begin miscompares++; $display("FAIL b2b_idle got %0d want 1", idle); end
  endtask

  task automatic test_reset_in_fcs();
    int d, k;
    for (int i = 0; i < 5; i++) pay[i] = 8'h5A ^ 8'(i);
    send_frame(5, 1, frame_dibits(5) - 16 + 5);
    rst = 1;
    @(negedge clk);
    vectors++;
    if ({txd, tx_en, s_ready, busy, underrun} !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_fcs_outputs got %b want 000000", {txd, tx_en, s_ready, busy, underrun});
    end
    rst = 0;
    @(negedge clk);
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE;
    send_frame(3, 1, 0);
    build_exp(3);
    vectors++; if (ncap !== 4 * nexp) begin miscompares++; $display("FAIL rst_new_len got %0d want %0d", ncap, 4 * nexp); end
    d = first_diff();
    vectors++; if (d != -1) begin miscompares++; $display("FAIL rst_new_stream byte %0d got %h want %h", d, cap_byte(d), expb[d]); end
    wait_idle(k);
    vectors++; if (n_ur != 0) begin miscompares++; $display("FAIL rst_new_underrun got %0d want 0", n_ur); end
  endtask

  initial begin
    test_reset();
    test_check_string();
    test_lengths();
    test_underrun();
    test_back_to_back();
    test_reset_in_fcs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
